sram_arbiter: RTL



---
 rtl/sram_arb_pkg.sv | 13 +
 rtl/rr_picker.sv | 27 ++
 rtl/sram_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter slice.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set bit of req at or after ptr, with wrap.
module rr_picker #(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned ReqIdxWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]      req,
  input  logic [ReqIdxWidth-1:0] ptr,
  output logic                   grant_valid,
  output logic [ReqIdxWidth-1:0] grant_idx
);

  logic [ReqIdxWidth-1:0] idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      idx = ReqIdxWidth'((32'(ptr) + off) % NumReq);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NumReq requesters,
// one outstanding access at a time.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned EleLen      = 32,
  parameter int unsigned EleIdxWidth = 10,
  parameter int unsigned ReqIdxWidth = $clog2(NumReq)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NumReq-1:0]                   req_valid,
  output logic [NumReq-1:0]                   req_ready,
  input  logic [NumReq-1:0]                   req_read_or_write,
  input  logic [NumReq-1:0][EleLen-1:0]       req_write_ele,
  input  logic [NumReq-1:0][EleIdxWidth-1:0]  req_addr,
  output logic [NumReq-1:0]                   resp_valid,
  input  logic [NumReq-1:0]                   resp_ready,
  output logic [EleLen-1:0]                   resp_read_ele,
  output logic                                sram_valid,
  output logic                                sram_read_or_write,
  output logic [EleLen-1:0]                   sram_write_ele,
  output logic [EleIdxWidth-1:0]              sram_addr,
  input  logic                                sram_ready,
  input  logic [EleLen-1:0]                   sram_read_ele
);

  arb_state_t             state_q;
  logic [ReqIdxWidth-1:0] rr_ptr_q;
  logic [ReqIdxWidth-1:0] owner_q;
  logic                   op_q;
  logic [EleIdxWidth-1:0] addr_q;
  logic [EleLen-1:0]      wdata_q;
  logic [EleLen-1:0]      rdata_q;

  logic                   grant_valid;
  logic [ReqIdxWidth-1:0] grant_idx;
  logic [ReqIdxWidth-1:0] ptr_next;

  rr_picker #(
    .NumReq      (NumReq),
    .ReqIdxWidth (ReqIdxWidth)
  ) u_rr_picker (
    .req         (req_valid),
    .ptr         (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign ptr_next = (grant_idx == ReqIdxWidth'(NumReq - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      op_q     <= OP_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_valid) begin
            owner_q  <= grant_idx;
            op_q     <= req_read_or_write[grant_idx];
            addr_q   <= req_addr[grant_idx];
            wdata_q  <= req_write_ele[grant_idx];
            rr_ptr_q <= ptr_next;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          if (sram_ready) begin
            if (op_q == OP_WRITE) begin
              state_q <= IDLE;
            end else begin
              rdata_q <= sram_read_ele;
              state_q <= RESP;
            end
          end
        end
        RESP: begin
          if (resp_ready[owner_q]) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grant is suppressed while rst is high so no requester sees a handshake that is dropped.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (state_q == IDLE && grant_valid && !rst) begin
      req_ready[grant_idx] = 1'b1;
    end
    if (state_q == RESP) begin
      resp_valid[owner_q] = 1'b1;
    end
  end

  assign sram_valid         = (state_q == ACCESS);
  assign sram_read_or_write = op_q;
  assign sram_addr          = addr_q;
  assign sram_write_ele     = wdata_q;
  assign resp_read_ele      = rdata_q;

endmodule
